// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead adder family.
//   GROUP_W    : lookahead group width in bits (fixed at 4)
//   num_groups : number of GROUP_W-bit groups in a given operand width
package cla_pkg;

  localparam int GROUP_W = 4;

  function automatic int num_groups(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group_lookahead.sv
// 4-bit carry-lookahead cell, purely combinational.
// Ports:
//   g_i[3:0], p_i[3:0] : per-position generate / propagate
//   c_i                : carry into position 0
//   c_o[2:0]           : carries into positions 1..3 (c1..c3)
//   g_grp_o, p_grp_o   : group generate / propagate over all 4 positions
// The same cell serves bit-level groups and the upper level that combines
// group G/P terms.
module cla_group_lookahead (
  input  logic [3:0] g_i,
  input  logic [3:0] p_i,
  input  logic       c_i,
  output logic [2:0] c_o,
  output logic       g_grp_o,
  output logic       p_grp_o
);

  assign c_o[0] = g_i[0] | (p_i[0] & c_i);
  assign c_o[1] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
  assign c_o[2] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & c_i);

  assign g_grp_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                 | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
  assign p_grp_o = &p_i;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// streaming on both sides.
// Optional feature macro: PIPELINED_CLA_OVF_EN adds the registered signed
// overflow output ovf.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : input handshake (a, b, c_in, sub)
//   sub                  : 0 -> a+b+c_in, 1 -> a-b (c_in ignored)
//   out_valid / out_ready: output handshake (sum, c_out[, ovf])
//   c_out                : carry out of MSB (for subtraction 1 = no borrow)
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPELINED_CLA_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int NG  = num_groups(WIDTH);
  localparam int NSB = (NG + 3) / 4;

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  // Operand preparation and per-bit generate/propagate
  logic [WIDTH-1:0] b_eff, g_in, p_in;
  logic             cin_eff;
  logic [NG*3-1:0]  gz_d;
  logic [NG-1:0]    grp_g_d, grp_p_d;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : c_in;
  assign g_in    = a & b_eff;
  assign p_in    = a ^ b_eff;

  // With zero carry-in the cell's internal carries are the group-prefix
  // generates; stage 2 only has to OR in the prefix-propagate of the
  // resolved group carry-in.
  for (genvar j = 0; j < NG; j++) begin : g_s1
    cla_group_lookahead u_grp (
      .g_i     (g_in[j*GROUP_W +: GROUP_W]),
      .p_i     (p_in[j*GROUP_W +: GROUP_W]),
      .c_i     (1'b0),
      .c_o     (gz_d[j*3 +: 3]),
      .g_grp_o (grp_g_d[j]),
      .p_grp_o (grp_p_d[j])
    );
  end

  // ---- Stage 1 registers -------------------------------------------------
  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] p_p1_q;
  logic [NG*3-1:0]  gz_p1_q;
  logic [NG-1:0]    grp_g_p1_q, grp_p_p1_q;
  logic             cin_p1_q;

  logic vld_p2_q, vld_p2_d;
  logic s2_en, s1_adv;

  assign s2_en    = !vld_p2_q || out_ready;
  assign s1_adv   = !vld_p1_q || s2_en;
  assign in_ready = s1_adv;

  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    if (s1_adv) vld_p1_d = in_valid;
    if (s2_en)  vld_p2_d = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      p_p1_q     <= '0;
      gz_p1_q    <= '0;
      grp_g_p1_q <= '0;
      grp_p_p1_q <= '0;
      cin_p1_q   <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      if (in_valid && s1_adv) begin
        p_p1_q     <= p_in;
        gz_p1_q    <= gz_d;
        grp_g_p1_q <= grp_g_d;
        grp_p_p1_q <= grp_p_d;
        cin_p1_q   <= cin_eff;
      end
    end
  end

  // Group carry resolution
  logic [NG-1:0] grp_cin;
  logic          top_cout;

  if (NG == 1) begin : g_single
    assign grp_cin  = cin_p1_q;
    assign top_cout = grp_g_p1_q[0] | (grp_p_p1_q[0] & cin_p1_q);
  end else begin : g_multi
    logic [NSB*4-1:0] grp_g_pad, grp_p_pad, grp_cin_full;
    logic [NSB:0]     sb_cin;

    // Unused upper slots pass carries straight through (G=0, P=1) so the
    // top super-block's carry-out equals the top group's carry-out.
    always_comb begin
      grp_g_pad         = '0;
      grp_p_pad         = '1;
      grp_g_pad[NG-1:0] = grp_g_p1_q;
      grp_p_pad[NG-1:0] = grp_p_p1_q;
    end

    assign sb_cin[0] = cin_p1_q;

    for (genvar k = 0; k < NSB; k++) begin : g_l2
      logic [2:0] c_int;
      logic       sb_g, sb_p;
      cla_group_lookahead u_l2 (
        .g_i     (grp_g_pad[k*4 +: 4]),
        .p_i     (grp_p_pad[k*4 +: 4]),
        .c_i     (sb_cin[k]),
        .c_o     (c_int),
        .g_grp_o (sb_g),
        .p_grp_o (sb_p)
      );
      assign grp_cin_full[k*4 +: 4] = {c_int, sb_cin[k]};
      assign sb_cin[k+1]            = sb_g | (sb_p & sb_cin[k]);
    end

    assign grp_cin  = grp_cin_full[NG-1:0];
    assign top_cout = sb_cin[NSB];
  end

  // Bit carries: prefix generate OR (prefix propagate AND group carry-in)
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;

  always_comb begin
    carry = '0;
    for (int j = 0; j < NG; j++) begin
      carry[j*4]   = grp_cin[j];
      carry[j*4+1] = gz_p1_q[j*3]   | (p_p1_q[j*4] & grp_cin[j]);
      carry[j*4+2] = gz_p1_q[j*3+1] | (&p_p1_q[j*4 +: 2] & grp_cin[j]);
      carry[j*4+3] = gz_p1_q[j*3+2] | (&p_p1_q[j*4 +: 3] & grp_cin[j]);
    end
  end

  assign sum_d = p_p1_q ^ carry;

  // ---- Stage 2 registers -------------------------------------------------
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else begin
      vld_p2_q <= vld_p2_d;
      if (s2_en && vld_p1_q) begin
        sum_q   <= sum_d;
        c_out_q <= top_cout;
      end
    end
  end

`ifdef PIPELINED_CLA_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (s2_en && vld_p1_q) begin
      ovf_q <= carry[WIDTH-1] ^ top_cout;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out_valid = vld_p2_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        c_in, sub, c_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [16:0] sb[$];
  int          pop_cycles[$];

  always #5 clk = ~clk;

`ifdef PIPELINED_CLA_OVF_EN
  logic       ovf16;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, c_in8, sub8, c_out8, ovf8;
  logic [7:0] a8, b8, sum8;
`endif

  pipelined_cla_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef PIPELINED_CLA_OVF_EN
    .ovf       (ovf16),
`endif
    .c_out     (c_out)
  );

`ifdef PIPELINED_CLA_OVF_EN
  pipelined_cla_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .c_in      (c_in8),
    .sub       (sub8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .ovf       (ovf8),
    .c_out     (c_out8)
  );
`endif

  function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mc, input logic ms);
    if (ms) return {1'b0, ma} + {1'b0, ~mb} + 17'd1;
    return {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    logic [16:0] exp_v;
    cyc++;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(model(a, b, c_in, sub));
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_output got=%h expected=none", {c_out, sum});
        end else begin
          exp_v = sb.pop_front();
          pop_cycles.push_back(cyc);
          if ({c_out, sum} !== exp_v) begin
            failures++;
            $display("FAIL sb_result got=%h expected=%h", {c_out, sum}, exp_v);
          end
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || c_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%h/%b expected=0/0000/0", out_valid, sum, c_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=%b/%b expected=1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_latency();
    a = 16'h1234; b = 16'h4321; c_in = 1'b1; sub = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_in_ready got=%b expected=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_early_valid got=%b expected=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h5556 || c_out !== 1'b0) begin
      failures++;
      $display("FAIL add_latency got=%b/%h/%b expected=1/5556/0", out_valid, sum, c_out);
    end
`ifdef PIPELINED_CLA_OVF_EN
    checks++;
    if (ovf16 !== 1'b0) begin
      failures++;
      $display("FAIL add_ovf got=%b expected=0", ovf16);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_carry_sub();
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h0000 || c_out !== 1'b1) begin
      failures++;
      $display("FAIL carry_wrap got=%b/%h/%b expected=1/0000/1", out_valid, sum, c_out);
    end
    @(posedge clk); #1;
    a = 16'h0005; b = 16'h0007; c_in = 1'b0; sub = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'hFFFE || c_out !== 1'b0) begin
      failures++;
      $display("FAIL sub_borrow got=%b/%h/%b expected=1/fffe/0", out_valid, sum, c_out);
    end
    @(posedge clk); #1;
    sub = 1'b0;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    pop_cycles.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready beat=%0d got=%b expected=1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (pop_cycles.size() != 8) begin
      failures++;
      $display("FAIL b2b_count got=%0d expected=8", pop_cycles.size());
    end else begin
      checks++;
      if (pop_cycles[7] - pop_cycles[0] != 7) begin
        failures++;
        $display("FAIL b2b_gapless got=%0d expected=7", pop_cycles[7] - pop_cycles[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          accepts = 0;
    logic        have_held = 1'b0;
    logic [15:0] held = '0;
    logic        acc;
    pop_cycles.delete();
    out_ready = 1'b0;
    a = 16'hA000; b = 16'h0BCD; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) accepts++;
      if (out_valid) begin
        if (have_held) begin
          checks++;
          if (sum !== held) begin
            failures++;
            $display("FAIL bp_hold got=%h expected=%h", sum, held);
          end
        end else begin
          held = sum;
          have_held = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (acc) begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
      end
    end
    @(negedge clk);
    checks++;
    if (accepts != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got=%0d/%b/%b expected=2/0/1", accepts, in_ready, out_valid);
    end
    checks++;
    if (sum !== 16'hABCD) begin
      failures++;
      $display("FAIL bp_first_held got=%h expected=abcd", sum);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    checks++;
    if (pop_cycles.size() != 2) begin
      failures++;
      $display("FAIL bp_release_count got=%0d expected=2", pop_cycles.size());
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h3333; b = 16'h4444;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_fill got=%b/%b expected=1/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0 || c_out !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_clear got=%b/%h/%b/%b expected=0/0000/0/1",
               out_valid, sum, c_out, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midrst_stale got=%0d expected=0", seen);
    end
    @(posedge clk); #1;
  endtask

`ifdef PIPELINED_CLA_OVF_EN
  task automatic test_ovf();
    out_ready8 = 1'b1;
    a8 = 8'h7F; b8 = 8'h01; c_in8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b1 || sum8 !== 8'h80 || c_out8 !== 1'b0 || ovf8 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_pos got=%b/%h/%b/%b expected=1/80/0/1", out_valid8, sum8, c_out8, ovf8);
    end
    @(posedge clk); #1;
    a8 = 8'h80; b8 = 8'h80; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b1 || sum8 !== 8'h00 || c_out8 !== 1'b1 || ovf8 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_neg got=%b/%h/%b/%b expected=1/00/1/1", out_valid8, sum8, c_out8, ovf8);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
`ifdef PIPELINED_CLA_OVF_EN
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; c_in8 = 1'b0; sub8 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_add_latency();
    test_carry_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef PIPELINED_CLA_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised two-stage pipelined carry-lookahead adder/subtractor with valid/ready streaming handshake on both sides.
- Stage 1 registers per-4-bit-group generate/propagate terms. Stage 2 resolves group carries by lookahead and produces sum and carry-out.
- Serves as the registered arithmetic primitive for datapaths needing WIDTH-bit add/sub at full throughput under backpressure.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- GROUP_W, 4, lookahead group width; fixed at 4 and taken from the shared package, not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  operands and mode valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+c_in; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of MSB. For subtraction, 1 means no borrow.

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following clear to 0: s1_valid, s2_valid, all stage-1 data registers, sum, c_out. out_valid is 0 during and after reset until new data propagates. in_ready is 1 in the first cycle after reset release.
- Input transfer: occurs on in_valid & in_ready. Output transfer: occurs on out_valid & out_ready.
- Operand prep: b_eff = sub ? ~b : b. cin_eff = sub ? 1 : c_in.
- Per bit: g = a & b_eff, p = a ^ b_eff.
- Stage 1, registered on input transfer:
  - p vector.
  - Per-group G and P (GROUP_W-bit lookahead).
  - cin_eff.
- Stage 2 carries: lookahead computes group carry-ins from the registered group G/P and cin_eff. Intra-group carries come from the registered p/g terms.
- Stage 2 outputs: sum = p ^ carries, c_out = carry out of the top group. Both are registered and held stable while out_valid=1 and out_ready=0.
- Stage-2 load enable: s2_en = !s2_valid | out_ready.
- Stage-1 advance: s1_adv = !s1_valid | s2_en.
- in_ready = s1_adv, purely combinational from state and out_ready. No combinational path from in_valid to in_ready.
- Latency: exactly 2 cycles from input transfer to out_valid with out_ready held high.
- Throughput: one result per cycle when out_ready is held high.
- Backpressure: with out_ready=0 the pipeline fills. At most 2 results are held, then in_ready=0. No result is dropped or duplicated.
- Simultaneous transfers:
  - Output and input transfer in the same cycle on a full pipeline: both stages advance, and the new operand enters stage 1.
  - Stage 1 empty and no input: s2_valid goes to 0 after the output transfer.
- Reset mid-operation: in-flight results are discarded. No out_valid pulse appears for them after reset.
- Width rules: arithmetic is unsigned modulo 2^WIDTH. WIDTH=4 degenerates to a single group with no upper lookahead level.

Optional Feature:
- Macro: PIPELINED_CLA_OVF_EN.
- When defined: adds output port ovf (1 bit), the signed two's-complement overflow of the operation. ovf = carry into MSB XOR carry out of MSB. It is registered alongside sum, resets to 0, and follows the same hold rules.
- When undefined: the port does not exist and no overflow logic is generated.

Decomposition:
- Package cla_pkg holds:
  - localparam GROUP_W = 4.
  - A function returning the number of groups for a given width (WIDTH/GROUP_W).
- One sub-module: cla_group_lookahead, combinational. It takes a 4-bit g, 4-bit p and a carry-in, and returns internal carries c1..c3 plus group G and P.
  - Instantiated per group in stage 1 (group G/P).
  - Instantiated again in stage 2 (carry resolution); for WIDTH>16, instances are chained hierarchically.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, c_in=1, sub=0, out_ready=1 -> sum=0x5556, c_out=0, out_valid exactly 2 cycles after accept.
- WIDTH=16, a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1. Then sub=1 with a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0 (borrow).
- Back-to-back stream of 8 random pairs, out_ready=1 -> 8 consecutive out_valid cycles, results in order and equal to a+b+c_in.
- out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops after 2 accepts, sum held stable. Release out_ready -> both results emitted in order, none lost.
- Assert rst_n=0 for one cycle with 2 results in flight -> out_valid=0, sum=0, c_out=0 next cycle, and no stale result appears afterwards.
- With PIPELINED_CLA_OVF_EN, WIDTH=8, a=0x7F, b=0x01 -> sum=0x80, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, c_out=1, ovf=1.
